// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared constants and FSM encoding for the vector memory unit
package vec_pkg;

    localparam int ELEM_W   = 16;
    localparam int NUM_ELEM = 16;
    localparam int ADDR_W   = 16;
    localparam int VEC_W    = ELEM_W * NUM_ELEM;
    localparam int IDX_W    = $clog2(NUM_ELEM);

    localparam logic OP_VLD = 1'b0;
    localparam logic OP_VST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/vector_mem_unit.sv
// rtl/vector_mem_unit.sv - VLD/VST executor moving one vector element per memory handshake
module vector_mem_unit
    import vec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [VEC_W-1:0]  st_data,
    output logic              busy,
    output logic              done,
    output logic [VEC_W-1:0]  ld_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ELEM_W-1:0] mem_wr_data,
    input  logic [ELEM_W-1:0] mem_rd_data,
    input  logic              mem_rdy
);

    state_t state;
    state_t state_nxt;

    logic [IDX_W-1:0]                   idx;
    logic [ADDR_W-1:0]                  base_q;
    logic                               op_q;
    logic [NUM_ELEM-1:0][ELEM_W-1:0]    snap_q;
    logic [NUM_ELEM-1:0][ELEM_W-1:0]    shadow_q;
    logic [NUM_ELEM-1:0][ELEM_W-1:0]    shadow_fill;
    logic                               last_elem;

    assign last_elem = (idx == IDX_W'(NUM_ELEM - 1));

    // Shadow buffer with the current element merged in, so the final element reaches ld_data on the DONE edge
    always_comb begin
        shadow_fill      = shadow_q;
        shadow_fill[idx] = mem_rd_data;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and memory-port outputs; requests only ever leave the unit in ACCESS
    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        done        = 1'b0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                busy     = 1'b1;
                mem_addr = base_q + ADDR_W'(idx);
                if (op_q == OP_VST) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_data = snap_q[idx];
                end else begin
                    mem_rd_en = 1'b1;
                end
                if (mem_rdy && last_elem) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Launch snapshot, element counter, load assembly and result publication
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            base_q   <= '0;
            op_q     <= OP_VLD;
            snap_q   <= '0;
            shadow_q <= '0;
            ld_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx    <= '0;
                        base_q <= base_addr;
                        op_q   <= is_store;
                        snap_q <= st_data;
                    end
                end
                ST_ACCESS: begin
                    if (mem_rdy) begin
                        idx <= idx + 1'b1;
                        if (op_q == OP_VLD) begin
                            shadow_q <= shadow_fill;
                            if (last_elem) begin
                                ld_data <= shadow_fill;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
